// File: rtl/vending_machine_fsm_if.sv
// Coin/selection bus between the acceptor/buttons and the vending controller.
// Dispense and change codes travel back on the same bundle.
interface vending_machine_fsm_if;
    logic [1:0] money;
    logic [1:0] select;
    logic [1:0] item;
    logic [1:0] change;

    modport master (output money, output select, input item, input change);
    modport slave  (input money, input select, output item, output change);
endinterface

// File: rtl/vending_machine_fsm.sv
// Two-product vending controller: tracks credit from 10/50 coins and emits
// one-cycle registered dispense and change pulses.
module vending_machine_fsm (
    input  logic                  clk,
    input  logic                  reset,
    vending_machine_fsm_if.slave  bus
);
    localparam int unsigned CODE_W = 2;

    localparam logic [CODE_W-1:0] MONEY_10   = CODE_W'(1);
    localparam logic [CODE_W-1:0] MONEY_50   = CODE_W'(2);
    localparam logic [CODE_W-1:0] SEL_A      = CODE_W'(1);
    localparam logic [CODE_W-1:0] SEL_B      = CODE_W'(2);
    localparam logic [CODE_W-1:0] ITEM_NONE  = CODE_W'(0);
    localparam logic [CODE_W-1:0] ITEM_A     = CODE_W'(1);
    localparam logic [CODE_W-1:0] ITEM_B     = CODE_W'(2);
    localparam logic [CODE_W-1:0] CHANGE_0   = CODE_W'(0);
    localparam logic [CODE_W-1:0] CHANGE_10  = CODE_W'(1);
    localparam logic [CODE_W-1:0] CHANGE_30  = CODE_W'(2);
    localparam logic [CODE_W-1:0] CHANGE_40  = CODE_W'(3);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT10 = 2'd1,
        CREDIT50 = 2'd2,
        CREDIT60 = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CODE_W-1:0]  item_q, item_nxt;
    logic [CODE_W-1:0]  change_q, change_nxt;

    // State and output pulse registers; reset discards any held credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            item_q   <= ITEM_NONE;
            change_q <= CHANGE_0;
        end else begin
            state    <= state_nxt;
            item_q   <= item_nxt;
            change_q <= change_nxt;
        end
    end

    // Below 50 only coins matter; at 50 or more only selections matter.
    always_comb begin
        state_nxt  = state;
        item_nxt   = ITEM_NONE;
        change_nxt = CHANGE_0;
        unique case (state)
            IDLE: begin
                if (bus.money == MONEY_10) begin
                    state_nxt = CREDIT10;
                end else if (bus.money == MONEY_50) begin
                    state_nxt = CREDIT50;
                end
            end
            CREDIT10: begin
                if (bus.money == MONEY_10) begin
                    // Exactly 20 credited: item A is bought without a selection.
                    state_nxt = IDLE;
                    item_nxt  = ITEM_A;
                end else if (bus.money == MONEY_50) begin
                    state_nxt = CREDIT60;
                end
            end
            CREDIT50: begin
                if (bus.select == SEL_A) begin
                    state_nxt  = IDLE;
                    item_nxt   = ITEM_A;
                    change_nxt = CHANGE_30;
                end else if (bus.select == SEL_B) begin
                    state_nxt  = IDLE;
                    item_nxt   = ITEM_B;
                end
            end
            CREDIT60: begin
                if (bus.select == SEL_A) begin
                    state_nxt  = IDLE;
                    item_nxt   = ITEM_A;
                    change_nxt = CHANGE_40;
                end else if (bus.select == SEL_B) begin
                    state_nxt  = IDLE;
                    item_nxt   = ITEM_B;
                    change_nxt = CHANGE_10;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.item   = item_q;
    assign bus.change = change_q;
endmodule

// File: tb/tb_vending_machine_fsm.sv
// Bench for vending_machine_fsm: directed scenarios plus random coin/select
// traffic checked against a credit-arithmetic reference model.
module tb_vending_machine_fsm;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Reference model: credit in coin units, expected registered outputs.
    int         credit;
    logic [1:0] exp_item;
    logic [1:0] exp_change;

    vending_machine_fsm_if vif ();

    vending_machine_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] change_code(input int amount);
        case (amount)
            0:       return 2'd0;
            10:      return 2'd1;
            30:      return 2'd2;
            40:      return 2'd3;
            default: return 2'dx;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model, compare both outputs.
    task automatic step(input logic r, input logic [1:0] m, input logic [1:0] s);
        int coin;
        int price;
        @(negedge clk);
        reset      = r;
        vif.money  = m;
        vif.select = s;
        @(posedge clk);
        exp_item   = 2'd0;
        exp_change = 2'd0;
        coin  = (m == 2'd1) ? 10 : (m == 2'd2) ? 50 : 0;
        price = (s == 2'd1) ? 20 : (s == 2'd2) ? 50 : 0;
        if (r) begin
            credit = 0;
        end else if (credit < 50) begin
            credit += coin;
            if (credit == 20) begin
                exp_item = 2'd1;
                credit   = 0;
            end
        end else if (price != 0) begin
            exp_item   = (price == 20) ? 2'd1 : 2'd2;
            exp_change = change_code(credit - price);
            credit     = 0;
        end
        #1;
        check("item", int'(vif.item), int'(exp_item));
        check("change", int'(vif.change), int'(exp_change));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        credit     = 0;
        exp_item   = 2'd0;
        exp_change = 2'd0;
        reset      = 1'b1;
        vif.money  = 2'd0;
        vif.select = 2'd0;

        // Reset, then two 10-coins buy item A automatically.
        step(1'b1, 2'd0, 2'd0);
        step(1'b1, 2'd0, 2'd0);
        check("reset_item", int'(vif.item), 0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd0, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        check("auto_a_item", int'(vif.item), 1);
        check("auto_a_change", int'(vif.change), 0);
        step(1'b0, 2'd0, 2'd0);
        check("pulse_end", int'(vif.item), 0);

        // 60 credit, select A then B.
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd0, 2'd1);
        check("c60_a_change", int'(vif.change), 3);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd0, 2'd2);
        check("c60_b_item", int'(vif.item), 2);
        check("c60_b_change", int'(vif.change), 1);

        // 50 credit, select A then B.
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd0, 2'd1);
        check("c50_a_change", int'(vif.change), 2);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd0, 2'd2);
        check("c50_b_item", int'(vif.item), 2);

        // Ignored inputs: selects with low credit, invalid coin, extra coin at 50.
        step(1'b0, 2'd0, 2'd1);
        step(1'b0, 2'd3, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd0, 2'd1);
        step(1'b0, 2'd3, 2'd0);
        check("c10_sel_ignored", int'(vif.item), 0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd2, 2'd0);
        step(1'b0, 2'd1, 2'd0);
        step(1'b0, 2'd0, 2'd2);
        check("extra_coin_change", int'(vif.change), 0);

        // Reset mid-transaction beats a simultaneous select.
        step(1'b0, 2'd2, 2'd0);
        step(1'b1, 2'd0, 2'd1);
        check("reset_mid_item", int'(vif.item), 0);
        step(1'b0, 2'd0, 2'd1);
        check("post_reset_sel", int'(vif.item), 0);

        // Random traffic, biased toward idle cycles, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] m;
            logic [1:0] s;
            r = ($urandom_range(0, 63) == 0);
            m = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            s = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            step(r, m, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
